// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with FWFT/registered read, programmable almost flags,
// occupancy count, sticky overflow/underflow and synchronous flush.
module sync_fifo_flags #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter bit          FWFT      = 1'b0,
   parameter int unsigned AF_THRESH = 14,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic             wr_acc;
   logic             rd_acc;
   logic [PW-1:0]    wr_ptr_n;
   logic [PW-1:0]    rd_ptr_n;
   logic [CW-1:0]    count_n;
   logic [WIDTH-1:0] dout_n;
   logic             dout_valid_n;
   logic             overflow_n;
   logic             underflow_n;

   // Accept decisions; flush suppresses both operations.
   always_comb begin
      wr_acc = wr_en && !full && !clr;
      rd_acc = rd_en && !empty && !clr;
   end

   // Next pointers, count and sticky error flags.
   always_comb begin
      wr_ptr_n    = wr_ptr;
      rd_ptr_n    = rd_ptr;
      count_n     = count;
      overflow_n  = overflow | (wr_en && full);
      underflow_n = underflow | (rd_en && empty);
      if (wr_acc) begin
         wr_ptr_n = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
         rd_ptr_n = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
         count_n = count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_n = count - CW'(1);
      end
      if (clr) begin
         wr_ptr_n    = '0;
         rd_ptr_n    = '0;
         count_n     = '0;
         overflow_n  = 1'b0;
         underflow_n = 1'b0;
      end
   end

   // Read data path. In FWFT mode the head word is precomputed so dout stays
   // registered; when the FIFO would otherwise be empty the head is the
   // incoming word, which is not yet in the array. A flush empties the FIFO,
   // so FWFT dout returns to 0 while registered-read dout holds.
   always_comb begin
      dout_n       = dout;
      dout_valid_n = 1'b0;
      if (FWFT) begin
         dout_valid_n = (count_n != '0);
         if (count_n == '0) begin
            dout_n = '0;
         end else if ((count - CW'(rd_acc)) == '0) begin
            dout_n = din;
         end else begin
            dout_n = mem[rd_ptr_n];
         end
      end else begin
         dout_valid_n = rd_acc;
         if (rd_acc) begin
            dout_n = mem[rd_ptr];
         end
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   // State and registered outputs; flags decode the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'(AF_THRESH == 0);
         almost_empty <= 1'b1;
         dout         <= '0;
         dout_valid   <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_n;
         rd_ptr       <= rd_ptr_n;
         count        <= count_n;
         full         <= (count_n == CW'(DEPTH));
         empty        <= (count_n == '0);
         almost_full  <= (count_n >= CW'(AF_THRESH));
         almost_empty <= (count_n <= CW'(AE_THRESH));
         dout         <= dout_n;
         dout_valid   <= dout_valid_n;
         overflow     <= overflow_n;
         underflow    <= underflow_n;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a registered-read and an FWFT instance.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_clr, a_wr_en, a_rd_en;
   logic [7:0] a_din, a_dout;
   logic       a_dv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
   logic [4:0] a_count;
   logic       b_clr, b_wr_en, b_rd_en;
   logic [7:0] b_din, b_dout;
   logic       b_dv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
   logic [4:0] b_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0), .AF_THRESH(14), .AE_THRESH(2)) u_reg (
      .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_en(a_wr_en), .din(a_din), .rd_en(a_rd_en),
      .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty), .almost_full(a_af),
      .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un));

   sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_en(b_wr_en), .din(b_din), .rd_en(b_rd_en),
      .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty), .almost_full(b_af),
      .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un));

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_a();
      a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = 8'h00;
   endtask

   task automatic test_reset();
      idle_a();
      b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = 8'h00;
      rst_n = 1'b0;
      tick();
      checks++;
      if ({a_count, a_empty, a_full, a_ae, a_af, a_dout, a_dv, a_ov, a_un} !==
          {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b dout=%h dv=%b ov=%b un=%b, required 0 1 0 1 0 00 0 0 0",
                  a_count, a_empty, a_full, a_ae, a_af, a_dout, a_dv, a_ov, a_un);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         a_wr_en = 1'b1; a_din = 8'(i);
         tick();
         checks++;
         if ({a_count, a_af, a_full, a_ae} !== {5'(i), i >= 14, i == 16, i <= 2}) begin
            errors++;
            $display("FAIL fill_%0d: count=%0d af=%b full=%b ae=%b, required %0d %b %b %b",
                     i, a_count, a_af, a_full, a_ae, i, i >= 14, i == 16, i <= 2);
         end
      end
      a_din = 8'h11;
      tick();
      a_wr_en = 1'b0;
      checks++;
      if ({a_ov, a_count, a_full} !== {1'b1, 5'd16, 1'b1}) begin
         errors++;
         $display("FAIL overflow_write: ov=%b count=%0d full=%b, required 1 16 1", a_ov, a_count, a_full);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         a_rd_en = 1'b1;
         tick();
         checks++;
         if ({a_dout, a_dv, a_count} !== {8'(i), 1'b1, 5'(16 - i)}) begin
            errors++;
            $display("FAIL drain_%0d: dout=%h dv=%b count=%0d, required %h 1 %0d",
                     i, a_dout, a_dv, a_count, 8'(i), 16 - i);
         end
      end
      a_rd_en = 1'b0;
      tick();
      checks++;
      if ({a_dv, a_empty, a_un} !== {1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL drain_end: dv=%b empty=%b un=%b, required 0 1 0", a_dv, a_empty, a_un);
      end
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      checks++;
      if ({a_un, a_dout, a_dv, a_count} !== {1'b1, 8'h10, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL underflow_read: un=%b dout=%h dv=%b count=%0d, required 1 10 0 0",
                  a_un, a_dout, a_dv, a_count);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] q[$];
      logic [7:0] exp_v;
      int         bad;
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_wr_en = 1'b1; a_din = 8'(8'h20 + i); q.push_back(a_din);
         tick();
      end
      bad = 0;
      for (int i = 5; i < 45; i++) begin
         a_wr_en = 1'b1; a_rd_en = 1'b1; a_din = 8'(8'h20 + i); q.push_back(a_din);
         tick();
         exp_v = q.pop_front();
         checks++;
         if ({a_count, a_dout, a_dv} !== {5'd5, exp_v, 1'b1}) begin
            errors++;
            bad++;
            if (bad < 5)
               $display("FAIL simul_%0d: count=%0d dout=%h dv=%b, required 5 %h 1",
                        i, a_count, a_dout, a_dv, exp_v);
         end
      end
      idle_a();
      tick();
   endtask

   task automatic test_full_rw();
      logic [7:0] got [16];
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      checks++;
      if ({a_ov, a_un, a_count} !== {1'b0, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL clr_before_full: ov=%b un=%b count=%0d, required 0 0 0", a_ov, a_un, a_count);
      end
      for (int i = 0; i < 16; i++) begin
         a_wr_en = 1'b1; a_din = 8'(8'h30 + i);
         tick();
      end
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_din = 8'hAA;
      tick();
      idle_a();
      checks++;
      if ({a_dout, a_count, a_ov, a_full} !== {8'h30, 5'd15, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL full_rw: dout=%h count=%0d ov=%b full=%b, required 30 15 1 0",
                  a_dout, a_count, a_ov, a_full);
      end
      for (int i = 1; i < 16; i++) begin
         a_rd_en = 1'b1;
         tick();
         got[i] = a_dout;
      end
      a_rd_en = 1'b0;
      for (int i = 1; i < 16; i++) begin
         checks++;
         if (got[i] !== 8'(8'h30 + i)) begin
            errors++;
            $display("FAIL full_rw_drain_%0d: dout=%h, required %h", i, got[i], 8'(8'h30 + i));
         end
      end
      tick();
      checks++;
      if (a_empty !== 1'b1) begin
         errors++;
         $display("FAIL full_rw_empty: empty=%b, required 1", a_empty);
      end
   endtask

   task automatic test_clr();
      for (int i = 0; i < 3; i++) begin
         a_wr_en = 1'b1; a_din = 8'(8'h60 + i);
         tick();
      end
      a_wr_en = 1'b0; a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      a_clr = 1'b1; a_wr_en = 1'b1; a_din = 8'h55;
      tick();
      idle_a();
      checks++;
      if ({a_count, a_empty, a_full, a_af, a_ae, a_ov, a_un, a_dv, a_dout} !==
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60}) begin
         errors++;
         $display("FAIL clr_mid_burst: count=%0d empty=%b full=%b af=%b ae=%b ov=%b un=%b dv=%b dout=%h, required 0 1 0 0 1 0 0 0 60",
                  a_count, a_empty, a_full, a_af, a_ae, a_ov, a_un, a_dv, a_dout);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         a_wr_en = 1'b1; a_din = 8'(8'h70 + i);
         tick();
      end
      a_wr_en = 1'b0; a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_count, a_empty, a_full, a_ae, a_af, a_dout, a_dv, a_ov, a_un} !==
          {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: count=%0d empty=%b full=%b ae=%b af=%b dout=%h dv=%b ov=%b un=%b, required 0 1 0 1 0 00 0 0 0",
                  a_count, a_empty, a_full, a_ae, a_af, a_dout, a_dv, a_ov, a_un);
      end
      idle_a();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fwft();
      b_wr_en = 1'b1; b_din = 8'hA5;
      tick();
      b_wr_en = 1'b0;
      checks++;
      if ({b_dout, b_dv, b_count, b_empty} !== {8'hA5, 1'b1, 5'd1, 1'b0}) begin
         errors++;
         $display("FAIL fwft_first_word: dout=%h dv=%b count=%0d empty=%b, required a5 1 1 0",
                  b_dout, b_dv, b_count, b_empty);
      end
      tick();
      checks++;
      if ({b_dout, b_dv} !== {8'hA5, 1'b1}) begin
         errors++;
         $display("FAIL fwft_hold: dout=%h dv=%b, required a5 1", b_dout, b_dv);
      end
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      checks++;
      if ({b_dout, b_dv, b_empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL fwft_pop_empty: dout=%h dv=%b empty=%b, required 00 0 1", b_dout, b_dv, b_empty);
      end
      b_wr_en = 1'b1; b_din = 8'hB1;
      tick();
      b_din = 8'hB2;
      tick();
      b_wr_en = 1'b0;
      checks++;
      if ({b_dout, b_count} !== {8'hB1, 5'd2}) begin
         errors++;
         $display("FAIL fwft_head_b1: dout=%h count=%0d, required b1 2", b_dout, b_count);
      end
      b_rd_en = 1'b1;
      tick();
      checks++;
      if ({b_dout, b_dv, b_count} !== {8'hB2, 1'b1, 5'd1}) begin
         errors++;
         $display("FAIL fwft_head_b2: dout=%h dv=%b count=%0d, required b2 1 1", b_dout, b_dv, b_count);
      end
      tick();
      b_rd_en = 1'b0;
      checks++;
      if ({b_dout, b_dv, b_empty, b_un} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL fwft_drained: dout=%h dv=%b empty=%b un=%b, required 00 0 1 0",
                  b_dout, b_dv, b_empty, b_un);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_full_rw();
      test_clr();
      test_async_reset();
      test_fwft();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
